// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: skid FSM state
// encoding and the default bundle widths used at each stage boundary.
package pipe_pkg;

  // Encoding doubles as the held-entry count (o_occupancy).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int IF_ID_DATA_W   = 64;
  localparam int IF_ID_CTRL_W   = 2;
  localparam int ID_EX_DATA_W   = 96;
  localparam int ID_EX_CTRL_W   = 8;
  localparam int EX_MEM_DATA_W  = 96;
  localparam int EX_MEM_CTRL_W  = 6;
  localparam int MEM_WB_DATA_W  = 64;
  localparam int MEM_WB_CTRL_W  = 4;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag plus data and control bundles.
// Clear drops the entry and zeroes ctrl but leaves data untouched, so a
// bubble can never carry a live write enable while the wide data path
// avoids needless toggling.
module pipe_entry_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Entry register; clear has priority over load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, flush and clock enable.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no entry held, M and S invalid
//   ST_ONE   | M holds the oldest entry, S invalid
//   ST_TWO   | M holds the oldest entry, S holds the next one
//
// With SKID = 0 only M exists and ready is combinational from i_out_ready.
// With SKID = 1 ready is decoded purely from the registered state, which
// breaks the ready path between stages at the cost of the extra S entry.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_en,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [1:0]        o_occupancy
);

  // Flush only acts on enabled cycles; a held pipeline ignores it.
  logic w_flush;
  assign w_flush = i_flush & i_clk_en;

  generate
    if (SKID != 0) begin : g_skid
      pipe_state_e       r_state;
      pipe_state_e       w_state_nxt;
      logic              w_in_ready;
      logic              w_it;
      logic              w_ot;
      logic              w_m_load;
      logic              w_m_clear;
      logic              w_s_load;
      logic              w_s_clear;
      logic              w_m_valid;
      logic [DATA_W-1:0] w_m_data;
      logic [CTRL_W-1:0] w_m_ctrl;
      logic [DATA_W-1:0] w_m_din;
      logic [CTRL_W-1:0] w_m_cin;
      logic              w_s_valid;
      logic [DATA_W-1:0] w_s_data;
      logic [CTRL_W-1:0] w_s_ctrl;

      assign w_in_ready = i_clk_en & (r_state != ST_TWO);
      assign w_it       = i_in_valid & w_in_ready & ~i_flush;
      assign w_ot       = w_m_valid & i_out_ready & i_clk_en;

      // M refills from S when draining TWO, otherwise from the input.
      assign w_m_din = w_s_valid ? w_s_data : i_in_data;
      assign w_m_cin = w_s_valid ? w_s_ctrl : i_in_ctrl;

      // State register; frozen while the clock enable is low.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_state <= ST_EMPTY;
        end else if (i_clk_en) begin
          r_state <= w_state_nxt;
        end
      end

      // Next-state and entry load/clear decode; flush overrides everything.
      always_comb begin
        w_state_nxt = r_state;
        w_m_load    = 1'b0;
        w_m_clear   = 1'b0;
        w_s_load    = 1'b0;
        w_s_clear   = 1'b0;
        if (w_flush) begin
          w_state_nxt = ST_EMPTY;
          w_m_clear   = 1'b1;
          w_s_clear   = 1'b1;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_it) begin
                w_state_nxt = ST_ONE;
                w_m_load    = 1'b1;
              end
            end
            ST_ONE: begin
              if (w_it && w_ot) begin
                w_m_load = 1'b1;
              end else if (w_it) begin
                w_state_nxt = ST_TWO;
                w_s_load    = 1'b1;
              end else if (w_ot) begin
                w_state_nxt = ST_EMPTY;
                w_m_clear   = 1'b1;
              end
            end
            ST_TWO: begin
              if (w_ot) begin
                w_state_nxt = ST_ONE;
                w_m_load    = 1'b1;
                w_s_clear   = 1'b1;
              end
            end
            default: begin
              w_state_nxt = ST_EMPTY;
              w_m_clear   = 1'b1;
              w_s_clear   = 1'b1;
            end
          endcase
        end
      end

      pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_data  (w_m_din),
        .i_ctrl  (w_m_cin),
        .o_valid (w_m_valid),
        .o_data  (w_m_data),
        .o_ctrl  (w_m_ctrl)
      );

      pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_data  (i_in_data),
        .i_ctrl  (i_in_ctrl),
        .o_valid (w_s_valid),
        .o_data  (w_s_data),
        .o_ctrl  (w_s_ctrl)
      );

      assign o_in_ready  = w_in_ready;
      assign o_out_valid = w_m_valid;
      assign o_out_data  = w_m_data;
      assign o_out_ctrl  = w_m_valid ? w_m_ctrl : '0;
      assign o_occupancy = r_state;
    end else begin : g_single
      logic              w_in_ready;
      logic              w_it;
      logic              w_ot;
      logic              w_load;
      logic              w_clear;
      logic              w_valid;
      logic [DATA_W-1:0] w_data;
      logic [CTRL_W-1:0] w_ctrl;

      assign w_in_ready = i_clk_en & (~w_valid | i_out_ready);
      assign w_it       = i_in_valid & w_in_ready & ~i_flush;
      assign w_ot       = w_valid & i_out_ready & i_clk_en;
      assign w_load     = w_it;
      assign w_clear    = w_flush | (w_ot & ~w_it);

      pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_data  (i_in_data),
        .i_ctrl  (i_in_ctrl),
        .o_valid (w_valid),
        .o_data  (w_data),
        .o_ctrl  (w_ctrl)
      );

      assign o_in_ready  = w_in_ready;
      assign o_out_valid = w_valid;
      assign o_out_data  = w_data;
      assign o_out_ctrl  = w_valid ? w_ctrl : '0;
      assign o_occupancy = {1'b0, w_valid};
    end
  endgenerate

endmodule
